// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch front end. Owns the PC and issues one
//               outstanding request at a time to instruction memory. It
//               presents fetched words to IF/ID, freezes that output on hold,
//               and flushes it on a jump. A one-entry skid buffer catches a
//               response that lands while IF is held.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                HOLD_W   = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_to_i,
  input  logic [HOLD_W-1:0] hold_code_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  localparam logic [0:0]        c_ST_IDLE = 1'b0;
  localparam logic [0:0]        c_ST_WAIT = 1'b1;
  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_kill;
  logic              r_skid_valid;
  logic [INST_W-1:0] r_skid_inst;
  logic [ADDR_W-1:0] r_skid_pc;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;

  logic              w_hold;
  logic              w_ack_live;
  logic              w_ack_keep;
  logic [ADDR_W-1:0] w_jmp_pc;
  logic              w_unused_jmp_lsb;

  // Decode of control inputs: a response only counts in WAIT, and is kept
  // only when it is neither killed by an earlier jump nor by one this cycle.
  always_comb begin
    w_hold           = |hold_code_i;
    w_ack_live       = (r_state == c_ST_WAIT) && imem_ack_i;
    w_ack_keep       = w_ack_live && !r_kill && !jmp_en_i;
    w_jmp_pc         = {jmp_to_i[ADDR_W-1:2], 2'b00};
    w_unused_jmp_lsb = ^jmp_to_i[1:0];
    w_pc_nxt         = r_pc;
    if (jmp_en_i) begin
      w_pc_nxt = w_jmp_pc;
    end else if (w_ack_keep) begin
      w_pc_nxt = r_pc + c_PC_STEP;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: issue when free; stay in WAIT back-to-back only when the
  // kept word went straight to the output (skid stays empty).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (!jmp_en_i && !w_hold && !r_skid_valid) begin
          w_state_nxt = c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (imem_ack_i) begin
          w_state_nxt = (w_ack_keep && !w_hold) ? c_ST_WAIT : c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    imem_req_o   = (r_state == c_ST_WAIT);
    imem_addr_o  = r_addr;
    inst_valid_o = r_inst_valid;
    inst_o       = r_inst;
    inst_pc_o    = r_inst_pc;
  end

  // PC, request address, kill flag, skid buffer and IF/ID output register.
  // The request address is frozen while a request is outstanding so that a
  // redirect only moves the PC, never the in-flight address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_inst  <= '0;
      r_skid_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (!((r_state == c_ST_WAIT) && !imem_ack_i)) begin
        r_addr <= w_pc_nxt;
      end

      if (jmp_en_i) begin
        r_kill <= (r_state == c_ST_WAIT) && !imem_ack_i;
      end else if (w_ack_live) begin
        r_kill <= 1'b0;
      end

      if (jmp_en_i) begin
        r_inst_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_hold) begin
        if (w_ack_keep) begin
          r_skid_valid <= 1'b1;
          r_skid_inst  <= imem_rdata_i;
          r_skid_pc    <= r_pc;
        end
      end else if (w_ack_keep) begin
        r_inst_valid <= 1'b1;
        r_inst       <= imem_rdata_i;
        r_inst_pc    <= r_pc;
      end else if (r_skid_valid) begin
        r_inst_valid <= 1'b1;
        r_inst       <= r_skid_inst;
        r_inst_pc    <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else begin
        r_inst_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch: directed scenarios followed
//               by randomized hold/jump/ack traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          HOLD_W   = 3;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_to;
  logic [HOLD_W-1:0] hold_code;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  if_fetch #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .HOLD_W   (HOLD_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jmp_en_i     (jmp_en),
    .jmp_to_i     (jmp_to),
    .hold_code_i  (hold_code),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a fetch unit is either busy (one request in flight,
  // possibly doomed by a redirect) or free; delivered words sit in a shown
  // slot plus a queue of parked words.
  bit          m_busy;
  bit          m_doomed;
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_out_v;
  logic [31:0] m_out_i;
  logic [31:0] m_out_p;
  logic [63:0] m_parked[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void model_reset();
    m_busy     = 1'b0;
    m_doomed   = 1'b0;
    m_pc       = RESET_PC;
    m_req_addr = RESET_PC;
    m_out_v    = 1'b0;
    m_out_i    = '0;
    m_out_p    = '0;
    m_parked.delete();
  endfunction

  function automatic void model_step();
    bit          held       = (hold_code != 0);
    bit          was_busy   = m_busy;
    bit          got        = m_busy && imem_ack;
    bit          had_parked = (m_parked.size() != 0);
    bit          fresh      = 1'b0;
    logic [63:0] word       = '0;
    if (jmp_en) begin
      m_pc    = {jmp_to[31:2], 2'b00};
      m_out_v = 1'b0;
      m_parked.delete();
      if (m_busy && !got) begin
        m_doomed = 1'b1;
      end else begin
        m_doomed = 1'b0;
        m_busy   = 1'b0;
      end
    end else begin
      if (got && m_doomed) begin
        m_doomed = 1'b0;
        m_busy   = 1'b0;
      end else if (got) begin
        fresh = 1'b1;
        word  = {m_pc, mem_word(m_pc)};
        m_pc  = m_pc + 32'd4;
      end
      if (held) begin
        if (fresh) m_parked.push_back(word);
      end else if (fresh) begin
        m_out_v = 1'b1;
        m_out_p = word[63:32];
        m_out_i = word[31:0];
      end else if (had_parked) begin
        word    = m_parked.pop_front();
        m_out_v = 1'b1;
        m_out_p = word[63:32];
        m_out_i = word[31:0];
      end else begin
        m_out_v = 1'b0;
      end
      if (fresh) m_busy = !held;
      else if (!was_busy) m_busy = !held && !had_parked;
    end
    if (!(was_busy && m_busy && !got)) m_req_addr = m_pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ":req"},   32'(imem_req_o),   32'(m_busy));
    check({ph, ":addr"},  imem_addr_o,       m_req_addr);
    check({ph, ":valid"}, 32'(inst_valid_o), 32'(m_out_v));
    if (m_out_v) begin
      check({ph, ":inst"},    inst_o,    m_out_i);
      check({ph, ":inst_pc"}, inst_pc_o, m_out_p);
    end
  endtask

  task automatic drive(input bit j, input logic [31:0] t, input logic [2:0] h, input bit a);
    jmp_en     = j;
    jmp_to     = t;
    hold_code  = h;
    imem_ack   = a;
    imem_rdata = (a && imem_req_o) ? mem_word(imem_addr_o) : $urandom;
  endtask

  task automatic tick(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 3'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset:inst", inst_o, 32'h0);
    check("reset:inst_pc", inst_pc_o, 32'h0);
    rst_n = 1'b1;

    // Zero-wait memory from reset: 0,4,8,C back-to-back.
    tick("boot");
    check("boot:first_req", 32'(imem_req_o), 32'd1);
    check("boot:first_addr", imem_addr_o, 32'h0);
    for (int k = 0; k < 12 && !(m_out_v && m_out_p == 32'hC); k++) begin
      drive(1'b0, '0, 3'd0, imem_req_o);
      tick("zw");
    end
    check("zw:out_pc_c", inst_pc_o, 32'hC);
    check("zw:addr_10", imem_addr_o, 32'h10);

    // Hold for three cycles with 0x10 outstanding.
    drive(1'b0, '0, 3'd1, 1'b0); tick("hold1");
    drive(1'b0, '0, 3'd1, 1'b1); tick("hold2");
    check("hold2:no_req", 32'(imem_req_o), 32'd0);
    check("hold2:frozen", inst_pc_o, 32'hC);
    drive(1'b0, '0, 3'd1, 1'b0); tick("hold3");
    check("hold3:frozen", inst_pc_o, 32'hC);
    drive(1'b0, '0, 3'd0, 1'b0); tick("release");
    check("release:skid_pc", inst_pc_o, 32'h10);
    check("release:skid_inst", inst_o, mem_word(32'h10));
    drive(1'b0, '0, 3'd0, 1'b0); tick("resume");
    check("resume:addr", imem_addr_o, 32'h14);
    check("resume:req", 32'(imem_req_o), 32'd1);

    // Jump to 0x103 while the 0x20 request waits.
    for (int k = 0; k < 12 && !(m_busy && m_req_addr == 32'h20); k++) begin
      drive(1'b0, '0, 3'd0, imem_req_o);
      tick("to20");
    end
    drive(1'b0, '0, 3'd0, 1'b0);        tick("jw1");
    drive(1'b1, 32'h103, 3'd0, 1'b0);   tick("jmp");
    check("jmp:valid", 32'(inst_valid_o), 32'd0);
    check("jmp:still_req", 32'(imem_req_o), 32'd1);
    check("jmp:addr_stable", imem_addr_o, 32'h20);
    drive(1'b0, '0, 3'd0, 1'b1);        tick("kill_ack");
    check("kill_ack:valid", 32'(inst_valid_o), 32'd0);
    drive(1'b0, '0, 3'd0, 1'b0);        tick("after_kill");
    check("after_kill:addr", imem_addr_o, 32'h100);

    // Jump in the same cycle as the ack for 0x40.
    drive(1'b1, 32'h38, 3'd0, 1'b1);    tick("jmp38");
    for (int k = 0; k < 12 && !(m_busy && m_req_addr == 32'h40); k++) begin
      drive(1'b0, '0, 3'd0, imem_req_o);
      tick("to40");
    end
    drive(1'b1, 32'h200, 3'd0, 1'b1);   tick("jmp_ack");
    check("jmp_ack:valid", 32'(inst_valid_o), 32'd0);
    check("jmp_ack:no_req", 32'(imem_req_o), 32'd0);
    drive(1'b0, '0, 3'd0, 1'b0);        tick("after_jmp_ack");
    check("after_jmp_ack:addr", imem_addr_o, 32'h200);
    drive(1'b0, '0, 3'd0, 1'b1);        tick("fetch200");
    check("fetch200:pc", inst_pc_o, 32'h200);

    // Simultaneous jump and hold.
    drive(1'b1, 32'h300, 3'd5, 1'b1);   tick("jmp_hold");
    check("jmp_hold:valid", 32'(inst_valid_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 3'd2, 1'b0);      tick("jh_wait");
      check("jh_wait:no_req", 32'(imem_req_o), 32'd0);
    end
    drive(1'b0, '0, 3'd0, 1'b0);        tick("jh_rel");
    check("jh_rel:addr", imem_addr_o, 32'h300);

    // Reset mid-WAIT, then a stray ack right after release.
    drive(1'b0, '0, 3'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid:req", 32'(imem_req_o), 32'd0);
    check("rst_mid:addr", imem_addr_o, RESET_PC);
    check("rst_mid:valid", 32'(inst_valid_o), 32'd0);
    check("rst_mid:inst", inst_o, 32'h0);
    check("rst_mid:inst_pc", inst_pc_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 3'd0, 1'b1);        tick("stray");
    check("stray:first_addr", imem_addr_o, RESET_PC);
    check("stray:valid", 32'(inst_valid_o), 32'd0);
    drive(1'b0, '0, 3'd0, 1'b1);        tick("post_rst");
    check("post_rst:pc", inst_pc_o, RESET_PC);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bit          j;
      bit          a;
      logic [31:0] t;
      logic [2:0]  h;
      j = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      h = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      a = imem_req_o ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      drive(j, t, h, a);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end of the pipeline; the consumer of the pipeline controller's jump redirect and hold code.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents fetched instructions to the IF/ID stage, and freezes or flushes that output as the hold/jump signals dictate.
- Contains a one-entry skid buffer so that an in-flight response arriving during a hold is never lost.

Parameters:
ADDR_W, 32, PC / memory address width
INST_W, 32, instruction width
HOLD_W, 3, hold code width
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
jmp_en_i  in  1  redirect pulse from pipeline control
jmp_to_i  in  ADDR_W  redirect target
hold_code_i  in  HOLD_W  0 = run; any nonzero value = hold IF
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address
imem_ack_i  in  1  one-cycle response strobe; rdata valid same cycle
imem_rdata_i  in  INST_W  fetched instruction
inst_valid_o  out  1  IF/ID output valid
inst_o  out  INST_W  instruction to IF/ID
inst_pc_o  out  ADDR_W  PC of inst_o

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; kill=0; skid empty.
  - imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- State machine: IDLE, WAIT.
  - imem_req_o=(state==WAIT); imem_addr_o=pc; both driven from registers.
  - Request and address stay stable in WAIT until imem_ack_i. Requests are never aborted.
- IDLE -> WAIT: when hold_code_i==0, skid empty, and no jump this cycle. The first request appears the cycle after reset release.
- WAIT + ack, not killed, no jump this cycle:
  - If the output register is free or being consumed (hold_code_i==0): load inst_o=rdata, inst_pc_o=pc, inst_valid_o=1.
  - Otherwise the word goes to the skid buffer.
  - pc<=pc+4, wrapping modulo 2^ADDR_W.
  - Stay in WAIT (back-to-back; one instruction per cycle with zero-wait memory) if hold_code_i==0 and the skid is empty after this cycle; else go to IDLE.
- WAIT + ack with kill=1: discard data, kill<=0, pc unchanged (already redirected), go to IDLE.
- Hold (hold_code_i!=0): inst_valid_o/inst_o/inst_pc_o frozen; no new request issued; an outstanding request still completes into the skid.
- Hold release: if the skid is valid, the output loads from the skid and the skid empties. Fetch resumes the next cycle.
- Consume: when hold_code_i==0 and nothing new is loaded, inst_valid_o<=0.
- Jump (jmp_en_i=1), which has priority over hold and ack:
  - pc<={jmp_to_i[ADDR_W-1:2],2'b00}.
  - inst_valid_o<=0; skid cleared.
  - If in WAIT without ack this cycle: kill<=1, stay in WAIT until the ack.
  - If ack in the same cycle: data dropped, go to IDLE.
  - A second jump while kill=1 only updates pc.
- Latency: request -> inst_valid_o is ack cycle +1.
- Reset mid-transaction: all state cleared immediately. A later stray ack while in IDLE is ignored.

Test Plan:
- Reset then zero-wait memory (ack the cycle after req): addresses 0,4,8,C on consecutive cycles; inst_valid_o high continuously from cycle 2 with matching inst_pc_o.
- hold_code_i=1 for 3 cycles while a request to 0x10 is outstanding and the output holds 0x0C: output frozen at 0x0C, 0x10 data goes to the skid, no req; on release, output shows 0x10, then req 0x14.
- jmp_en_i with jmp_to_i=0x103 while the request to 0x20 waits 2 cycles: 0x20 data discarded, inst_valid_o=0, next req addr=0x100.
- jmp_en_i in the same cycle as the ack for 0x40, target 0x200: 0x40 never appears on inst_o; next req=0x200.
- Simultaneous jump and hold: pc=target, output flushed, no req until hold clears, then req=target.
- rst_n low mid-WAIT then ack asserted after release: outputs at reset values, the stray ack is ignored, first req=RESET_PC.
